demux_sched: RTL and testbench
==============================

# demux_sched

Sequencing front end for the 1:2 demultiplexer datapath. It accepts a stream of data words over a valid/ready handshake and steers each word to one of two output channels. The destination comes either from a per-word select (`in_dest`) or from an internal round-robin pointer. Each channel has a one-entry output register, so back-pressure on one channel never corrupts data bound for the other.

## Interface
- `WIDTH`, 8, data word width in bits.
- `CNT_W`, 8, width of the per-channel transfer counters.

- `clk`  input  1  clock; all state updates on the rising edge.
- `reset`  input  1  asynchronous, active-high reset.
- `in_valid`  input  1  input word present.
- `in_data`  input  WIDTH  input word.
- `in_dest`  input  1  requested channel (0/1); ignored when `rr_mode`=1.
- `in_ready`  output  1  block accepts the word this cycle.
- `rr_mode`  input  1  0: route by `in_dest`; 1: route by round-robin pointer.
- `rr_ptr`  output  1  current round-robin pointer.
- `out0_valid` / `out1_valid`  output  1  channel holds a word.
- `out0_data` / `out1_data`  output  WIDTH  channel word.
- `out0_ready` / `out1_ready`  input  1  channel consumer takes the word.
- `cnt0` / `cnt1`  output  CNT_W  completed output transfers per channel.

## Operation
- Target channel `t` = `rr_mode` ? `rr_ptr` : `in_dest`.
- Each channel slot has two states:
  - EMPTY to FULL: on acceptance targeting this channel.
  - FULL to EMPTY: on `outN_valid & outN_ready` with no acceptance targeting this channel.
  - FULL stays FULL: on simultaneous drain and acceptance. The slot reloads with the new word.
- `in_ready` = slot[t] EMPTY, or slot[t] draining this cycle (`outt_ready`=1). This path is combinational from `in_dest`, `rr_mode` and `outN_ready`.
- Acceptance = `in_valid & in_ready`. It loads `in_data` into slot[t]. The other slot is untouched.
- `outN_data` is stable while `outN_valid`=1 and `outN_ready`=0. It changes only on a load.
- `rr_ptr` toggles on every acceptance made while `rr_mode`=1. It holds while `rr_mode`=0. A `rr_mode` change takes effect on the next acceptance; `rr_ptr` is not reset by the mode change.
- The two channels drain independently. Both may complete a transfer in the same cycle.
- `cntN` increments by 1 on each `outN_valid & outN_ready`. It wraps modulo 2^CNT_W, so all-ones goes to 0.
- `in_valid`=0 causes no state change other than drains.

## Timing
- Reset (asynchronous, immediate):
  - `out0_valid`=`out1_valid`=0 and both `outN_data`=0.
  - `rr_ptr`=0 and `cnt0`=`cnt1`=0.
  - `in_ready` then evaluates to 1.
- Latency: a word accepted at edge k appears with `outN_valid`=1 after edge k, i.e. one cycle.
- Throughput: one word per cycle into a channel whose consumer holds ready=1.
  - In round-robin mode, alternate channels are filled each cycle.
- Blocking: with slot[t] FULL and `outt_ready`=0, `in_ready`=0. The other slot still drains.
  - In `rr_mode`, a blocked target stalls the input. The pointer does not skip the stalled channel.
- Reset asserted mid-operation discards both slots immediately. Words held in the slots are lost, and the counters clear.
- `outN_valid` never deasserts without a handshake, except under reset.

## Configuration
- `DEMUX_SCHED_CNT_EN` defined: the `cnt0`/`cnt1` counter registers and their increment logic are built as described above.
- `DEMUX_SCHED_CNT_EN` not defined: no counter registers are built. `cnt0`/`cnt1` remain ports, tied constantly to 0. All other behaviour is identical.

## Test plan
- Reset, then directed routing:
  - Stimulus: `rr_mode`=0; send 0xA5 with `in_dest`=0, then 0x3C with `in_dest`=1, both outputs ready=1.
  - Required: `out0` carries 0xA5 one cycle after acceptance, and `out1` carries 0x3C one cycle after its acceptance. `in_ready` stays 1 throughout.
- Back-pressure:
  - Stimulus: `out0_ready`=0; send 0x11 then 0x22, both to dest 0.
  - Required: the first word is accepted and `in_ready` drops to 0. `out0_data` holds 0x11. Raising `out0_ready` for one cycle completes 0x11 and accepts 0x22 in the same cycle. 0x22 appears the next cycle.
- Round-robin:
  - Stimulus: `rr_mode`=1; send 0x01..0x04 back-to-back with `in_dest` held at 1.
  - Required: 0x01 and 0x03 go to `out0`; 0x02 and 0x04 go to `out1`. `rr_ptr` sequence is 0,1,0,1,0. No stall cycles occur.
- Independence:
  - Stimulus: `out1_ready`=0 with `out1` FULL; stream to dest 0.
  - Required: `out0` sustains one word per cycle, and `out1_data` is unchanged.
- Counter wrap (with `DEMUX_SCHED_CNT_EN`):
  - Stimulus: 256 transfers on channel 0 at `CNT_W`=8.
  - Required: `cnt0` returns to 0 and `cnt1`=0.
  - Without the macro, `cnt0`/`cnt1` read 0 throughout.
- Reset mid-stream:
  - Stimulus: assert `reset` between edges with both slots FULL and `rr_ptr`=1.
  - Required: both `outN_valid`=0 and `rr_ptr`=0 immediately, without waiting for an edge.

Source files
------------

// File: rtl/demux_sched.sv
// demux_sched: valid/ready 1:2 demux with per-channel output registers and optional
// per-channel transfer counters (DEMUX_SCHED_CNT_EN).
module demux_sched #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_dest,
  output logic             in_ready,
  input  logic             rr_mode,
  output logic             rr_ptr,
  output logic             out0_valid,
  output logic [WIDTH-1:0] out0_data,
  input  logic             out0_ready,
  output logic             out1_valid,
  output logic [WIDTH-1:0] out1_data,
  input  logic             out1_ready,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1
);
  logic t, acc, dr0, dr1;
  assign t = rr_mode ? rr_ptr : in_dest;
  assign dr0 = out0_valid & out0_ready;
  assign dr1 = out1_valid & out1_ready;
  assign in_ready = t ? (!out1_valid || out1_ready) : (!out0_valid || out0_ready);
  assign acc = in_valid & in_ready;
  // a load wins over a drain so a slot draining and reloading stays full
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      out0_valid <= 1'b0;
      out1_valid <= 1'b0;
      out0_data <= '0;
      out1_data <= '0;
      rr_ptr <= 1'b0;
    end else begin
      if (acc && !t) begin
        out0_valid <= 1'b1;
        out0_data <= in_data;
      end else if (dr0) out0_valid <= 1'b0;
      if (acc && t) begin
        out1_valid <= 1'b1;
        out1_data <= in_data;
      end else if (dr1) out1_valid <= 1'b0;
      if (acc && rr_mode) rr_ptr <= ~rr_ptr;
    end
`ifdef DEMUX_SCHED_CNT_EN
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      cnt0 <= '0;
      cnt1 <= '0;
    end else begin
      if (dr0) cnt0 <= cnt0 + 1'b1;
      if (dr1) cnt1 <= cnt1 + 1'b1;
    end
`else
  assign cnt0 = '0;
  assign cnt1 = '0;
`endif
endmodule

// File: tb/tb_demux_sched.sv
// tb_demux_sched: directed checks of demux_sched routing, back-pressure, round-robin, counters, reset.
module tb_demux_sched;
  logic clk = 1'b0, reset = 1'b1;
  logic in_valid = 1'b0, in_dest = 1'b0, rr_mode = 1'b0;
  logic [7:0] in_data = '0;
  logic out0_ready = 1'b1, out1_ready = 1'b1;
  logic in_ready, rr_ptr, out0_valid, out1_valid;
  logic [7:0] out0_data, out1_data, cnt0, cnt1;
  int total = 0, bad = 0;
`ifdef DEMUX_SCHED_CNT_EN
  localparam bit CE = 1'b1;
`else
  localparam bit CE = 1'b0;
`endif
  demux_sched #(.WIDTH(8), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_dest(in_dest),
    .in_ready(in_ready), .rr_mode(rr_mode), .rr_ptr(rr_ptr),
    .out0_valid(out0_valid), .out0_data(out0_data), .out0_ready(out0_ready),
    .out1_valid(out1_valid), .out1_data(out1_data), .out1_ready(out1_ready),
    .cnt0(cnt0), .cnt1(cnt1)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  initial begin
    #1;
    chk("rst out0_valid", out0_valid, 0);
    chk("rst out1_valid", out1_valid, 0);
    chk("rst out0_data", out0_data, 0);
    chk("rst rr_ptr", rr_ptr, 0);
    chk("rst cnt0", cnt0, 0);
    chk("rst in_ready", in_ready, 1);
    @(negedge clk);
    reset = 1'b0;
    step();
    // directed routing
    in_valid = 1'b1; in_data = 8'hA5; in_dest = 1'b0; #1;
    chk("dir rdy0", in_ready, 1);
    step();
    chk("dir out0_valid", out0_valid, 1);
    chk("dir out0_data", out0_data, 8'hA5);
    in_data = 8'h3C; in_dest = 1'b1; #1;
    chk("dir rdy1", in_ready, 1);
    step();
    chk("dir out1_valid", out1_valid, 1);
    chk("dir out1_data", out1_data, 8'h3C);
    chk("dir out0 drained", out0_valid, 0);
    in_valid = 1'b0;
    step();
    chk("dir out1 drained", out1_valid, 0);
    chk("dir cnt0", cnt0, CE ? 1 : 0);
    chk("dir cnt1", cnt1, CE ? 1 : 0);
    // back-pressure
    out0_ready = 1'b0; in_valid = 1'b1; in_data = 8'h11; in_dest = 1'b0; #1;
    chk("bp rdy first", in_ready, 1);
    step();
    chk("bp out0_data 11", out0_data, 8'h11);
    in_data = 8'h22; #1;
    chk("bp rdy blocked", in_ready, 0);
    step();
    chk("bp hold data", out0_data, 8'h11);
    chk("bp hold valid", out0_valid, 1);
    chk("bp still blocked", in_ready, 0);
    out0_ready = 1'b1; #1;
    chk("bp rdy drain", in_ready, 1);
    step();
    chk("bp reload valid", out0_valid, 1);
    chk("bp reload data", out0_data, 8'h22);
    chk("bp cnt0", cnt0, CE ? 2 : 0);
    in_valid = 1'b0;
    step();
    chk("bp drained", out0_valid, 0);
    // round-robin
    rr_mode = 1'b1; in_dest = 1'b1; in_valid = 1'b1;
    chk("rr ptr0", rr_ptr, 0);
    for (int i = 1; i <= 4; i++) begin
      in_data = 8'(i); #1;
      chk("rr rdy", in_ready, 1);
      step();
      chk("rr ptr", rr_ptr, i % 2);
      if (i % 2 == 1) begin
        chk("rr out0_data", out0_data, i);
        chk("rr out0_valid", out0_valid, 1);
      end else begin
        chk("rr out1_data", out1_data, i);
        chk("rr out1_valid", out1_valid, 1);
      end
    end
    in_valid = 1'b0; rr_mode = 1'b0;
    step();
    chk("rr cnt0", cnt0, CE ? 5 : 0);
    chk("rr cnt1", cnt1, CE ? 3 : 0);
    // independence
    out1_ready = 1'b0; in_valid = 1'b1; in_dest = 1'b1; in_data = 8'h77;
    step();
    chk("ind out1 full", out1_data, 8'h77);
    in_dest = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_data = 8'h40 + 8'(i); #1;
      chk("ind rdy", in_ready, 1);
      step();
      chk("ind out0_data", out0_data, 8'h40 + i);
      chk("ind out1_data", out1_data, 8'h77);
      chk("ind out1_valid", out1_valid, 1);
    end
    in_valid = 1'b0; in_dest = 1'b1; #1;
    chk("ind blocked dest1", in_ready, 0);
    out1_ready = 1'b1;
    step();
    chk("ind cnt0", cnt0, CE ? 9 : 0);
    chk("ind cnt1", cnt1, CE ? 4 : 0);
    // reset mid-stream with both slots full and rr_ptr=1
    out0_ready = 1'b0; out1_ready = 1'b0; in_valid = 1'b1;
    in_dest = 1'b0; in_data = 8'hAA;
    step();
    in_dest = 1'b1; in_data = 8'hBB;
    step();
    rr_mode = 1'b1; out0_ready = 1'b1; in_data = 8'hCC;
    step();
    in_valid = 1'b0; out0_ready = 1'b0;
    chk("pre rst out0_data", out0_data, 8'hCC);
    chk("pre rst out1_valid", out1_valid, 1);
    chk("pre rst rr_ptr", rr_ptr, 1);
    #1 reset = 1'b1;
    #1;
    chk("mid rst out0_valid", out0_valid, 0);
    chk("mid rst out1_valid", out1_valid, 0);
    chk("mid rst rr_ptr", rr_ptr, 0);
    chk("mid rst out1_data", out1_data, 0);
    chk("mid rst cnt0", cnt0, 0);
    @(negedge clk);
    reset = 1'b0; rr_mode = 1'b0; in_dest = 1'b0; out0_ready = 1'b1; out1_ready = 1'b1;
    // counter wrap
    in_valid = 1'b1;
    for (int i = 0; i < 256; i++) begin
      in_data = 8'(i);
      step();
    end
    chk("wrap cnt0 pre", cnt0, CE ? 255 : 0);
    in_valid = 1'b0;
    step();
    chk("wrap cnt0", cnt0, 0);
    chk("wrap cnt1", cnt1, 0);
    chk("wrap out0_valid", out0_valid, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
